fsqrt_pipe: RTL and testbench

- Pipelined IEEE-754 binary32 square-root unit for the FPU datapath.
- Accepts one operand per clock and returns the correctly rounded square root a fixed 3 cycles later.
- No handshake: fully pipelined, throughput 1 result/cycle.

---
 rtl/fpu_pkg.sv | 45 ++++
 rtl/sqrt_iter_stage.sv | 42 ++++
 rtl/fsqrt_pipe.sv | 121 ++++++++++++
 tb/tb_fsqrt_pipe.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, special-value constants and the sqrt
// special-case classification used by the FPU datapath.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int BIAS   = 127;
  localparam int ROOT_W = MAN_W + 2;   // hidden bit + mantissa + round bit
  localparam int REM_W  = ROOT_W + 1;  // remainder never exceeds 2*root

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ZERO   = 2'd1,
    NAN    = 2'd2,
    INF    = 2'd3
  } sqrt_kind_t;

  // Per-stage pipeline payload: special-case flag plus recurrence state.
  typedef struct packed {
    sqrt_kind_t          kind;
    logic                sign;
    logic [EXP_W-1:0]    er;
    logic [REM_W-1:0]    rem;
    logic [ROOT_W-1:0]   root;
  } stage_t;

  // Zero/denormal wins over sign so that -0 and negative denormals give -0.
  function automatic sqrt_kind_t classify(input logic [31:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = x[MAN_W+EXP_W-1:MAN_W];
    m = x[MAN_W-1:0];
    if (e == '0)
      return ZERO;
    if (x[31])
      return NAN;
    if (e == '1)
      return (m != '0) ? NAN : INF;
    return NORMAL;
  endfunction

endpackage

// File: rtl/sqrt_iter_stage.sv
// Purpose: K unrolled restoring square-root iterations, two radicand bits each.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sqrt_iter_stage
  import fpu_pkg::*;
#(
  parameter int K = 8
) (
  input  logic [REM_W-1:0]  rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [2*K-1:0]    bits,
  output logic [REM_W-1:0]  next_rem,
  output logic [ROOT_W-1:0] next_root
);

  logic [REM_W-1:0]  r;
  logic [ROOT_W-1:0] q;
  logic [REM_W+1:0]  t;
  logic [REM_W+1:0]  trial;

  // Each step appends one root bit: subtract 4q+1 when it fits.
  always_comb begin
    r     = rem;
    q     = root;
    t     = '0;
    trial = '0;
    for (int i = 0; i < K; i++) begin
      t     = {r, bits[2*(K-1-i) +: 2]};
      trial = {1'b0, q, 2'b01};
      if (t >= trial) begin
        t = t - trial;
        q = {q[ROOT_W-2:0], 1'b1};
      end else begin
        q = {q[ROOT_W-2:0], 1'b0};
      end
      r = t[REM_W-1:0];
    end
    next_rem  = r;
    next_root = q;
  end

endmodule

// File: rtl/fsqrt_pipe.sv
// Purpose: pipelined binary32 square root, round-to-nearest-even, FTZ inputs.
// Latency: 3 cycles after the sampling edge, one result per clock.
// Backpressure: none; every cycle accepts a new operand.
module fsqrt_pipe
  import fpu_pkg::*;
(
  input  logic [31:0] op1,
  output logic [31:0] result,
  input  logic        clk,
  input  logic        reset
);

  logic [EXP_W-1:0]  e_in;
  logic [MAN_W-1:0]  m_in;
  logic [49:0]       rad;
  logic [EXP_W-1:0]  er_in;
  sqrt_kind_t        kind_in;

  logic [REM_W-1:0]  rem1, rem2, rem3;
  logic [ROOT_W-1:0] root1, root2, root3;

  stage_t            s1, s2, s3;
  logic [31:0]       s1_rad;
  logic [15:0]       s2_rad;

  logic              round_bit;
  logic              sticky;
  logic              inc;
  logic [MAN_W:0]    man_sum;
  logic [EXP_W-1:0]  er_final;
  logic [31:0]       res_next;
  logic              unused_root_msb;

  assign e_in    = op1[MAN_W+EXP_W-1:MAN_W];
  assign m_in    = op1[MAN_W-1:0];
  assign kind_in = classify(op1);
  assign er_in   = EXP_W'(({1'b0, e_in} + 9'(BIAS)) >> 1);

  // Odd biased exponent means an even unbiased one: radicand is 1.M,
  // otherwise 2*(1.M); both scaled by 2^48 so the root lands at 2^24.
  assign rad = e_in[0] ? {2'b01, m_in, 25'b0} : {1'b1, m_in, 26'b0};

  sqrt_iter_stage #(.K(9)) u_iter1 (
    .rem       ('0),
    .root      ('0),
    .bits      (rad[49:32]),
    .next_rem  (rem1),
    .next_root (root1)
  );

  sqrt_iter_stage #(.K(8)) u_iter2 (
    .rem       (s1.rem),
    .root      (s1.root),
    .bits      (s1_rad[31:16]),
    .next_rem  (rem2),
    .next_root (root2)
  );

  sqrt_iter_stage #(.K(8)) u_iter3 (
    .rem       (s2.rem),
    .root      (s2.root),
    .bits      (s2_rad),
    .next_rem  (rem3),
    .next_root (root3)
  );

  // Q[24] is always set on the normal path and carries no information.
  assign unused_root_msb = s3.root[ROOT_W-1];

  assign round_bit = s3.root[0];
  assign sticky    = |s3.rem;
  assign inc       = round_bit & (sticky | s3.root[1]);
  assign man_sum   = {1'b0, s3.root[MAN_W:1]} + {{MAN_W{1'b0}}, inc};
  // A mantissa carry leaves man_sum[22:0] at zero and bumps the exponent.
  assign er_final  = s3.er + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};

  always_comb begin
    res_next = 32'h0;
    case (s3.kind)
      NORMAL:  res_next = {1'b0, er_final, man_sum[MAN_W-1:0]};
      ZERO:    res_next = {s3.sign, 31'b0};
      NAN:     res_next = QNAN;
      INF:     res_next = PINF;
      default: res_next = QNAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      s1_rad <= '0;
      s2_rad <= '0;
      result <= 32'h0;
    end else begin
      s1.kind <= kind_in;
      s1.sign <= op1[31];
      s1.er   <= er_in;
      s1.rem  <= rem1;
      s1.root <= root1;
      s1_rad  <= rad[31:0];

      s2.kind <= s1.kind;
      s2.sign <= s1.sign;
      s2.er   <= s1.er;
      s2.rem  <= rem2;
      s2.root <= root2;
      s2_rad  <= s1_rad[15:0];

      s3.kind <= s2.kind;
      s3.sign <= s2.sign;
      s3.er   <= s2.er;
      s3.rem  <= rem3;
      s3.root <= root3;

      result  <= res_next;
    end
  end

endmodule

// File: tb/tb_fsqrt_pipe.sv
// Directed and random checks of fsqrt_pipe against a scoreboard of expected
// results queued as each operand is driven.
module tb_fsqrt_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] op1;
  logic [31:0] result;

  int n_checks;
  int n_errors;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  fsqrt_pipe dut (
    .op1    (op1),
    .result (result),
    .clk    (clk),
    .reset  (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact double sqrt, then round-to-nearest-even to binary32.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] d;
    logic [10:0] de;
    logic [10:0] fe;
    logic [51:0] dm;
    logic [23:0] mr;
    logic        rb;
    logic        st;
    real         r;
    e = x[30:23];
    m = x[22:0];
    if (e == 8'd0) return {x[31], 31'b0};
    if (x[31]) return 32'h7FC00000;
    if (e == 8'hFF) return (m != 23'd0) ? 32'h7FC00000 : 32'h7F800000;
    d  = {1'b0, {3'b000, e} + 11'd896, m, 29'b0};
    r  = $sqrt($bitstoreal(d));
    d  = $realtobits(r);
    de = d[62:52];
    dm = d[51:0];
    rb = dm[28];
    st = |dm[27:0];
    mr = {1'b0, dm[51:29]} + {23'd0, rb & (st | dm[29])};
    fe = de - 11'd896 + {10'd0, mr[23]};
    return {1'b0, fe[7:0], mr[22:0]};
  endfunction

  // Drive one operand for one clock; compare the entry whose 3-cycle
  // latency has just elapsed. Reset zeroes everything still in flight.
  task automatic step(input logic [31:0] x, input logic [31:0] expv,
                      input logic rst, input string tag);
    logic [31:0] e;
    string       t;
    reset = rst;
    op1   = x;
    if (rst) begin
      foreach (exp_q[i]) exp_q[i] = 32'h0;
      exp_q.push_back(32'h0);
    end else begin
      exp_q.push_back(expv);
    end
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (rst) begin
      n_checks++;
      assert (result === 32'h0) else begin
        n_errors++;
        $error("FAIL reset_hold_%s: result=%h expected=00000000", tag, result);
      end
    end
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      assert (result === e) else begin
        n_errors++;
        $error("FAIL %s: result=%h expected=%h", t, result, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    op1      = 32'h40800000;

    step(32'h40800000, 32'h0, 1'b1, "reset0");
    step(32'h40800000, 32'h0, 1'b1, "reset1");

    step(32'h40800000, 32'h40000000, 1'b0, "four");
    step(32'h3F800000, 32'h3F800000, 1'b0, "one");
    step(32'h40000000, 32'h3FB504F3, 1'b0, "two");
    step(32'h41100000, 32'h40400000, 1'b0, "nine");
    step(32'h7F7FFFFF, 32'h5F7FFFFF, 1'b0, "max_finite");
    step(32'h7F800000, 32'h7F800000, 1'b0, "pos_inf");
    step(32'h7FC00001, 32'h7FC00000, 1'b0, "nan");
    step(32'hBF800000, 32'h7FC00000, 1'b0, "neg_one");
    step(32'hFF800000, 32'h7FC00000, 1'b0, "neg_inf");
    step(32'h80000000, 32'h80000000, 1'b0, "neg_zero");
    step(32'h00000001, 32'h00000000, 1'b0, "denormal");
    step(32'h00800000, 32'h20000000, 1'b0, "min_normal");

    step(32'h3F800000, 32'h3F800000, 1'b0, "b2b_1");
    step(32'h40800000, 32'h40000000, 1'b0, "b2b_4");
    step(32'h41100000, 32'h40400000, 1'b0, "b2b_9");
    step(32'h41800000, 32'h40800000, 1'b0, "b2b_16");

    step(32'h40000000, 32'h3FB504F3, 1'b0, "midflight_two");
    step(32'h41100000, 32'h0, 1'b1, "midflight_rst");
    step(32'h3F800000, 32'h3F800000, 1'b0, "after_rst_one");
    step(32'h40800000, 32'h40000000, 1'b0, "after_rst_four");

    for (int i = 0; i < 1000; i++) begin
      x = {1'b0, 31'($urandom)};
      for (int j = 0; j < 4; j++) step(x, ref_sqrt(x), 1'b0, "random");
    end

    for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, "drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
